// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    // Width for a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating wait counter: counts up on inc, clears on clr, flags when the limit is reached.
module arb_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam int CW = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign limit_hit = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port (IDLE/ISSUE/WAIT/RESP sequencing).
// Optional performance counters are enabled with `define MEM_ARBITER_PERF_EN.
//
// Handshake: a requester raises req with stable addr/data; gnt is a combinational
// pulse in IDLE and the request is captured on that edge; rvalid pulses once in RESP.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic [2:0]        d_funct3_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
`ifdef MEM_ARBITER_PERF_EN
    output logic [31:0]       if_grants_o,
    output logic [31:0]       d_grants_o,
    output logic [31:0]       stall_cycles_o,
`endif
    output arb_state_e        state_o,
    output logic              busy_o
);

    localparam int WCW = cnt_width(MEM_LAT - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_LAT - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    owner_e            owner_q;
    logic [AWIDTH-1:0] addr_q;
    logic              we_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [2:0]        funct3_q;
    logic [DWIDTH-1:0] rdata_q;
    logic [WCW-1:0]    wait_cnt_q;

    logic if_gnt;
    logic d_gnt;
    logic starve_hit;
    logic wait_last;
    logic resp;

    assign wait_last = (wait_cnt_q == WAIT_LAST);
    assign resp      = (state_q == RESP);

    // Data wins unless fetch has waited STARVE_LIMIT cycles; nothing is granted in reset.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst && (state_q == IDLE)) begin
            if (if_req_i && (starve_hit || !d_req_i)) begin
                if_gnt = 1'b1;
            end else if (d_req_i) begin
                d_gnt = 1'b1;
            end
        end
    end

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (rst),
        .inc       (if_req_i && !if_gnt),
        .clr       (!if_req_i || if_gnt),
        .limit_hit (starve_hit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (if_gnt || d_gnt) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (wait_last) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture at the grant edge; a fetch is always a word read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= OWN_IF;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            funct3_q <= '0;
        end else if (if_gnt) begin
            owner_q  <= OWN_IF;
            addr_q   <= if_addr_i;
            we_q     <= 1'b0;
            funct3_q <= FUNCT3_WORD;
        end else if (d_gnt) begin
            owner_q  <= OWN_D;
            addr_q   <= d_addr_i;
            we_q     <= d_we_i;
            wdata_q  <= d_wdata_i;
            funct3_q <= d_funct3_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            rdata_q    <= '0;
        end else begin
            if (state_q == ISSUE) begin
                wait_cnt_q <= '0;
            end else if ((state_q == WAIT) && !wait_last) begin
                wait_cnt_q <= wait_cnt_q + WCW'(1);
            end
            if ((state_q == WAIT) && wait_last) begin
                rdata_q <= we_q ? '0 : mem_rdata_i;
            end
        end
    end

    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign mem_funct3_o   = funct3_q;
    assign mem_read_en_o  = (state_q == ISSUE) && !we_q;
    assign mem_write_en_o = (state_q == ISSUE) && we_q;

    assign if_gnt_o    = if_gnt;
    assign d_gnt_o     = d_gnt;
    assign if_rvalid_o = resp && (owner_q == OWN_IF);
    assign d_rvalid_o  = resp && (owner_q == OWN_D);
    assign if_rdata_o  = if_rvalid_o ? rdata_q : '0;
    assign d_rdata_o   = d_rvalid_o ? rdata_q : '0;
    assign busy_o      = (state_q != IDLE);
    assign state_o     = state_q;

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] if_grants_q;
    logic [31:0] d_grants_q;
    logic [31:0] stall_q;
    logic        stalled;

    assign stalled = (if_req_i && !if_gnt) || (d_req_i && !d_gnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_grants_q <= '0;
            d_grants_q  <= '0;
            stall_q     <= '0;
        end else begin
            if (if_gnt)  if_grants_q <= if_grants_q + 32'd1;
            if (d_gnt)   d_grants_q  <= d_grants_q + 32'd1;
            if (stalled) stall_q     <= stall_q + 32'd1;
        end
    end

    assign if_grants_o    = if_grants_q;
    assign d_grants_o     = d_grants_q;
    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: fetch, load, store, starvation guard and mid-access reset.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [2:0]    d_funct3;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rdata;
    arb_state_e    state;
    logic          busy;
`ifdef MEM_ARBITER_PERF_EN
    logic [31:0]   if_grants;
    logic [31:0]   d_grants;
    logic [31:0]   stall_cycles;
    logic [31:0]   base_if;
    logic [31:0]   base_d;
    logic [31:0]   base_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .AWIDTH       (AW),
        .DWIDTH       (DW),
        .MEM_LAT      (1),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req),
        .if_addr_i      (if_addr),
        .if_gnt_o       (if_gnt),
        .if_rvalid_o    (if_rvalid),
        .if_rdata_o     (if_rdata),
        .d_req_i        (d_req),
        .d_we_i         (d_we),
        .d_addr_i       (d_addr),
        .d_wdata_i      (d_wdata),
        .d_funct3_i     (d_funct3),
        .d_gnt_o        (d_gnt),
        .d_rvalid_o     (d_rvalid),
        .d_rdata_o      (d_rdata),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_read_en_o  (mem_read_en),
        .mem_write_en_o (mem_write_en),
        .mem_funct3_o   (mem_funct3),
        .mem_rdata_i    (mem_rdata),
`ifdef MEM_ARBITER_PERF_EN
        .if_grants_o    (if_grants),
        .d_grants_o     (d_grants),
        .stall_cycles_o (stall_cycles),
`endif
        .state_o        (state),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here, outputs checked #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_funct3 = '0; mem_rdata = '0;

        // Reset state: nothing granted even with a request pending.
        repeat (3) tick();
        if_req = 1'b1;
        #1;
        check_eq("rst_if_gnt", if_gnt, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_read_en", mem_read_en, 1'b0);
        if_req = 1'b0;
        rst = 1'b1;

        // Fetch only.
        tick(); if_req = 1'b1; if_addr = 32'h0100_0000; #1;
        check_eq("f_if_gnt", if_gnt, 1'b1);
        check_eq("f_d_gnt", d_gnt, 1'b0);
        tick(); if_req = 1'b0; if_addr = 32'hFFFF_FFFF; mem_rdata = 32'h0000_0013; #1;
        check_eq("f_busy", busy, 1'b1);
        check_eq("f_read_en", mem_read_en, 1'b1);
        check_eq("f_write_en", mem_write_en, 1'b0);
        check_eq("f_mem_addr", mem_addr, 32'h0100_0000);
        check_eq("f_funct3", mem_funct3, 3'b010);
        tick(); #1;
        check_eq("f_read_en_off", mem_read_en, 1'b0);
        check_eq("f_addr_hold", mem_addr, 32'h0100_0000);
        check_eq("f_rvalid_early", if_rvalid, 1'b0);
        tick(); #1;
        check_eq("f_rvalid", if_rvalid, 1'b1);
        check_eq("f_rdata", if_rdata, 32'h0000_0013);
        check_eq("f_d_rvalid", d_rvalid, 1'b0);
        tick(); #1;
        check_eq("f_rvalid_off", if_rvalid, 1'b0);
        check_eq("f_idle", busy, 1'b0);

        // Simultaneous requests: data first, fetch after.
        tick();
        if_req = 1'b1; if_addr = 32'h0100_0004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0200_0004; d_funct3 = 3'b100;
        mem_rdata = 32'hA5A5_0004;
        #1;
        check_eq("b_d_gnt", d_gnt, 1'b1);
        check_eq("b_if_gnt", if_gnt, 1'b0);
        tick(); d_req = 1'b0; #1;
        check_eq("b_mem_addr", mem_addr, 32'h0200_0004);
        check_eq("b_funct3", mem_funct3, 3'b100);
        check_eq("b_read_en", mem_read_en, 1'b1);
        check_eq("b_if_gnt_busy", if_gnt, 1'b0);
        tick(); #1;
        tick(); #1;
        check_eq("b_d_rvalid", d_rvalid, 1'b1);
        check_eq("b_d_rdata", d_rdata, 32'hA5A5_0004);
        check_eq("b_if_rvalid_n3", if_rvalid, 1'b0);
        tick(); mem_rdata = 32'h0000_0093; #1;
        check_eq("b_if_gnt_n4", if_gnt, 1'b1);
        check_eq("b_d_rvalid_off", d_rvalid, 1'b0);
        tick(); if_req = 1'b0; #1;
        check_eq("b_if_addr", mem_addr, 32'h0100_0004);
        check_eq("b_if_funct3", mem_funct3, 3'b010);
        tick(); #1;
        tick(); #1;
        check_eq("b_if_rvalid", if_rvalid, 1'b1);
        check_eq("b_if_rdata", if_rdata, 32'h0000_0093);
        tick(); #1;

        // Starvation guard: both held high; grants go data, fetch (cycle 4), data (cycle 8).
`ifdef MEM_ARBITER_PERF_EN
        base_if = if_grants; base_d = d_grants; base_stall = stall_cycles;
`endif
        for (int c = 0; c < 9; c++) begin
            tick();
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h0100_0008;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0200_0008; d_funct3 = 3'b010;
                mem_rdata = 32'h1111_1111;
            end
            #1;
            check_eq($sformatf("s_if_gnt_c%0d", c), if_gnt, (c == 4));
            check_eq($sformatf("s_d_gnt_c%0d", c), d_gnt, (c == 0 || c == 8));
        end
        tick(); if_req = 1'b0; d_req = 1'b0; #1;
`ifdef MEM_ARBITER_PERF_EN
        check_eq("p_d_grants", d_grants - base_d, 32'd2);
        check_eq("p_if_grants", if_grants - base_if, 32'd1);
        check_eq("p_stall", stall_cycles - base_stall, 32'd9);
`endif
        tick(); #1;
        tick(); #1;
        check_eq("s_d_rvalid", d_rvalid, 1'b1);
        check_eq("s_d_rdata", d_rdata, 32'h1111_1111);
        tick(); #1;

        // Store.
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0200_0010; d_wdata = 32'hDEAD_BEEF;
        d_funct3 = 3'b010; mem_rdata = 32'h1234_5678;
        #1;
        check_eq("w_d_gnt", d_gnt, 1'b1);
        tick(); d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; #1;
        check_eq("w_write_en", mem_write_en, 1'b1);
        check_eq("w_read_en", mem_read_en, 1'b0);
        check_eq("w_mem_addr", mem_addr, 32'h0200_0010);
        check_eq("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_eq("w_funct3", mem_funct3, 3'b010);
        tick(); #1;
        check_eq("w_write_en_off", mem_write_en, 1'b0);
        check_eq("w_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
        tick(); #1;
        check_eq("w_d_rvalid", d_rvalid, 1'b1);
        check_eq("w_d_rdata", d_rdata, 32'h0);
        tick(); #1;
        check_eq("w_d_rvalid_off", d_rvalid, 1'b0);

        // Reset asserted in WAIT: access abandoned, pending fetch granted right after release.
        tick(); if_req = 1'b1; if_addr = 32'h0100_000C; #1;
        check_eq("r_if_gnt", if_gnt, 1'b1);
        tick(); #1;
        tick(); #1;
        check_eq("r_state_wait", state, WAIT);
        rst = 1'b0; #1;
        check_eq("r_busy", busy, 1'b0);
        check_eq("r_read_en", mem_read_en, 1'b0);
        check_eq("r_if_rvalid", if_rvalid, 1'b0);
        check_eq("r_if_gnt_in_rst", if_gnt, 1'b0);
        check_eq("r_mem_addr", mem_addr, 32'h0);
        tick(); #1;
        check_eq("r_no_rvalid", if_rvalid, 1'b0);
`ifdef MEM_ARBITER_PERF_EN
        check_eq("r_perf_if", if_grants, 32'd0);
        check_eq("r_perf_stall", stall_cycles, 32'd0);
`endif
        tick(); rst = 1'b1; mem_rdata = 32'h0000_0073; #1;
        check_eq("r_first_gnt", if_gnt, 1'b1);
        tick(); if_req = 1'b0; #1;
        check_eq("r_read_en_new", mem_read_en, 1'b1);
        check_eq("r_addr_new", mem_addr, 32'h0100_000C);
        check_eq("r_rvalid_n1", if_rvalid, 1'b0);
        tick(); #1;
        check_eq("r_rvalid_n2", if_rvalid, 1'b0);
        tick(); #1;
        check_eq("r_rvalid_n3", if_rvalid, 1'b1);
        check_eq("r_rdata", if_rdata, 32'h0000_0073);
        tick(); #1;
        check_eq("r_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
